// File: rtl/bp_update_ctrl_pkg.sv
// Shared branch-predictor types: set/way indices, resolved-branch record, BHT geometry.
// Pure declarations; no latency or backpressure of its own.
package lc3b_types;

   typedef logic [3:0] lc3b_set;
   typedef logic [1:0] lc3b_pc_ways;

   typedef struct packed {
      logic        hit;
      lc3b_pc_ways way;
      lc3b_set     set;
      logic        taken;
   } bp_res_t;

   localparam int BHT_SETS        = 16;
   localparam int BHT_WAYS        = 4;
   localparam int BHT_INIT_CYCLES = BHT_SETS * BHT_WAYS;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Resolve-stage to update-controller handshake: valid/ready plus the resolved branch fields.
// master = resolve stage, slave = controller; transfer on res_valid && res_ready.
interface bp_update_ctrl_if;
   import lc3b_types::*;

   logic        res_valid;
   logic        res_ready;
   logic        res_hit;
   lc3b_pc_ways res_way;
   lc3b_set     res_set;
   logic        res_taken;

   modport master (output res_valid, res_hit, res_way, res_set, res_taken, input res_ready);
   modport slave  (input res_valid, res_hit, res_way, res_set, res_taken, output res_ready);

endinterface

// File: rtl/bp_update_ctrl_fifo.sv
// bp_res_fifo: synchronous FIFO of resolved branches, head visible combinationally (0-cycle read).
// Pushes while full and pops while empty are ignored; caller gates push with !full.
module bp_res_fifo
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  bp_res_t wr_dat,
   output bp_res_t rd_dat,
   output logic    full,
   output logic    empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   bp_res_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_dat  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_dat;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// BHT/BTB write sequencer: 64-cycle clear sweep after reset, then retires one queued resolution per cycle.
// Writes are combinational from the FIFO head (BP_UPD_BYPASS_EN: straight from the input when empty); res_ready = !full.
module bp_update_ctrl
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   bp_update_ctrl_if.slave   res,
   input  lc3b_pc_ways       lru_way,
   output logic              bht_load,
   output logic              bht_clear,
   output logic              bht_br_result,
   output lc3b_pc_ways       bht_way,
   output lc3b_pc_ways       bht_lru,
   output lc3b_set           bht_set,
   output logic              btb_alloc,
   output logic              init_busy,
   output logic [15:0]       alloc_cnt
);

   typedef enum logic {INIT, RUN} state_t;

   state_t      state;
   logic [5:0]  init_cnt;
   logic [15:0] alloc_cnt_q;
   logic [15:0] alloc_cnt_next;

   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   bp_res_t     fifo_head;
   bp_res_t     fifo_in;
   bp_res_t     ret_ent;
   logic        ret_vld;
   logic        bypass_fire;

   assign fifo_in  = '{hit: res.res_hit, way: res.res_way, set: res.res_set, taken: res.res_taken};
   assign fifo_pop = (state == RUN) && !rst && !fifo_empty;
   assign alloc_cnt = alloc_cnt_q;

   bp_res_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .wr_dat (fifo_in),
      .rd_dat (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= INIT;
         init_cnt    <= '0;
         alloc_cnt_q <= '0;
      end else begin
         alloc_cnt_q <= alloc_cnt_next;
         case (state)
            INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == 6'(BHT_INIT_CYCLES - 1)) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   always_comb begin
      res.res_ready = 1'b0;
      bypass_fire   = 1'b0;
      ret_vld       = 1'b0;
      ret_ent       = fifo_head;
      bht_load      = 1'b0;
      bht_clear     = 1'b0;
      bht_br_result = 1'b0;
      bht_way       = '0;
      bht_lru       = '0;
      bht_set       = '0;
      btb_alloc     = 1'b0;
      init_busy     = 1'b0;
      // While rst is held the ports show init slot 0, so nothing queued can retire.
      if (rst) begin
         bht_load  = 1'b1;
         bht_clear = 1'b1;
         init_busy = 1'b1;
      end else if (state == INIT) begin
         bht_load  = 1'b1;
         bht_clear = 1'b1;
         bht_set   = init_cnt[5:2];
         bht_lru   = init_cnt[1:0];
         init_busy = 1'b1;
      end else begin
         res.res_ready = !fifo_full;
         if (!fifo_empty) begin
            ret_vld = 1'b1;
            ret_ent = fifo_head;
         end
`ifdef BP_UPD_BYPASS_EN
         else if (res.res_valid) begin
            bypass_fire = 1'b1;
            ret_vld     = 1'b1;
            ret_ent     = fifo_in;
         end
`endif
         if (ret_vld) begin
            bht_load = 1'b1;
            bht_set  = ret_ent.set;
            if (ret_ent.hit) begin
               bht_way       = ret_ent.way;
               bht_br_result = ret_ent.taken;
            end else begin
               bht_clear = 1'b1;
               btb_alloc = 1'b1;
               bht_lru   = lru_way;
            end
         end
      end
   end

   always_comb begin
      fifo_push = (state == RUN) && !rst && res.res_valid && res.res_ready && !bypass_fire;
      alloc_cnt_next = alloc_cnt_q;
      if (ret_vld && !ret_ent.hit && (fifo_pop || bypass_fire))
         alloc_cnt_next = sat_inc16(alloc_cnt_q);
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed and random resolutions against a queue-based reference model.
module tb_bp_update_ctrl;
   import lc3b_types::*;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [1:0]  lru_way;
   logic        bht_load, bht_clear, bht_br_result, btb_alloc, init_busy;
   logic [1:0]  bht_way, bht_lru;
   logic [3:0]  bht_set;
   logic [15:0] alloc_cnt;

   bp_update_ctrl_if rif();

   bp_update_ctrl #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .res           (rif),
      .lru_way       (lru_way),
      .bht_load      (bht_load),
      .bht_clear     (bht_clear),
      .bht_br_result (bht_br_result),
      .bht_way       (bht_way),
      .bht_lru       (bht_lru),
      .bht_set       (bht_set),
      .btb_alloc     (btb_alloc),
      .init_busy     (init_busy),
      .alloc_cnt     (alloc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bp_res_t   m_q[$];
   int        m_idx;
   bit        m_run;
   bit        m_hold;
   bit [15:0] m_cnt;
   bit        chk_on;
   bit        last_acc;

   task automatic ck(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit [15:0] sat(input bit [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // One clock cycle: drive, check combinational outputs mid-cycle, advance the model at the edge.
   task automatic cyc(input bit r, input bit v, input bit h, input logic [1:0] w,
                      input logic [3:0] s, input bit t, input logic [1:0] lru);
      bp_res_t e;
      bit have, byp, exp_rdy;
      rst = r; rif.res_valid = v; rif.res_hit = h; rif.res_way = w;
      rif.res_set = s; rif.res_taken = t; lru_way = lru;
      #2;
      have = 0; byp = 0; exp_rdy = 0; e = '0;
      if (r) begin
         if (chk_on) begin
            ck("rst_load", bht_load, 1); ck("rst_clear", bht_clear, 1);
            ck("rst_set", bht_set, 0);   ck("rst_lru", bht_lru, 0);
            ck("rst_ready", rif.res_ready, 0); ck("rst_alloc", btb_alloc, 0);
            ck("rst_busy", init_busy, 1);
         end
      end else if (!m_run) begin
         ck("init_load", bht_load, 1); ck("init_clear", bht_clear, 1);
         ck("init_set", bht_set, 16'(m_idx / 4)); ck("init_lru", bht_lru, 16'(m_idx % 4));
         ck("init_ready", rif.res_ready, 0); ck("init_busy", init_busy, 1);
         ck("init_alloc", btb_alloc, 0); ck("init_br", bht_br_result, 0);
         ck("init_cnt", alloc_cnt, m_cnt);
      end else begin
         exp_rdy = (m_q.size() < DEPTH);
         if (m_q.size() > 0) begin
            e = m_q[0]; have = 1;
         end
`ifdef BP_UPD_BYPASS_EN
         else if (v) begin
            e = '{hit: h, way: w, set: s, taken: t}; have = 1; byp = 1;
         end
`endif
         ck("run_ready", rif.res_ready, 16'(exp_rdy));
         ck("run_busy", init_busy, 0);
         ck("run_cnt", alloc_cnt, m_cnt);
         if (!m_hold) begin
            ck("run_load", bht_load, 16'(have));
            if (have) begin
               ck("run_set", bht_set, 16'(e.set));
               ck("run_clear", bht_clear, 16'(!e.hit));
               ck("run_alloc", btb_alloc, 16'(!e.hit));
               ck("run_br", bht_br_result, e.hit ? 16'(e.taken) : 16'd0);
               if (e.hit) ck("run_way", bht_way, 16'(e.way));
               else       ck("run_lru", bht_lru, 16'(lru));
            end else begin
               ck("idle_alloc", btb_alloc, 0);
               ck("idle_br", bht_br_result, 0);
            end
         end
      end
      last_acc = !r && m_run && v && exp_rdy;
      @(posedge clk); #1;
      if (r) begin
         m_q.delete(); m_idx = 0; m_run = 0; m_cnt = 0;
      end else if (!m_run) begin
         if (m_idx == BHT_INIT_CYCLES - 1) m_run = 1;
         else m_idx++;
      end else begin
         if (!m_hold && m_q.size() > 0) begin
            e = m_q.pop_front();
            if (!e.hit) m_cnt = sat(m_cnt);
         end else if (byp && !h) begin
            m_cnt = sat(m_cnt);
         end
         if (last_acc && !byp) m_q.push_back('{hit: h, way: w, set: s, taken: t});
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 2'($urandom), 4'($urandom), 0, 2'($urandom));
   endtask

   task automatic rnd(input bit v);
      cyc(0, v, 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * DEPTH && m_q.size() > 0; i++) idle();
   endtask

   initial begin
      rst = 1; rif.res_valid = 0; rif.res_hit = 0; rif.res_way = 0;
      rif.res_set = 0; rif.res_taken = 0; lru_way = 0;
      m_idx = 0; m_run = 0; m_hold = 0; m_cnt = 0; chk_on = 0;
      @(posedge clk); #1;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk_on = 1;
      cyc(1, 1, 0, 0, 0, 0, 0);
      ck("reset_cnt", alloc_cnt, 0);

      // Init sweep with res_valid held high; cycle 65 is the first RUN cycle.
      for (int i = 0; i < BHT_INIT_CYCLES; i++) rnd(1);
      drain();

      // Single hit, then single miss
      cyc(0, 1, 1, 2'd2, 4'd5, 0, 2'd0);
      idle();
      cyc(0, 1, 0, 2'd1, 4'd9, 1, 2'd3);
      cyc(0, 0, 0, 2'd0, 4'd0, 0, 2'd3);
      idle();
      ck("miss_cnt", alloc_cnt, 1);

      // Hold the head so the FIFO fills, then push 5 more in a row
      force dut.fifo_pop = 1'b0;
      m_hold = 1;
      for (int i = 0; i < DEPTH; i++)
         cyc(0, 1, 1, 2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
      cyc(0, 1, 1, 2'd3, 4'd15, 1, 2'd0);
      ck("full_refused", 16'(last_acc), 0);
      release dut.fifo_pop;
      m_hold = 0;
      begin
         int n = 0;
         for (int i = 0; i < 12 && n < 5; i++) begin
            rnd(1);
            if (last_acc) n++;
         end
         ck("five_accepted", 16'(n), 5);
      end
      drain();

      // Random traffic
      for (int i = 0; i < 300; i++) rnd(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      drain();

      // Counter saturation
      force dut.alloc_cnt_q = 16'hFFFE;
      m_cnt = 16'hFFFE;
      idle();
      release dut.alloc_cnt_q;
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 2'($urandom), 4'($urandom), 0, 2'($urandom));
      drain();
      idle();
      ck("sat_cnt", alloc_cnt, 16'hFFFF);

      // Reset with three entries queued
      force dut.fifo_pop = 1'b0;
      m_hold = 1;
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 2'($urandom), 4'($urandom), 1, 2'($urandom));
      release dut.fifo_pop;
      m_hold = 0;
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      ck("rst_cnt_cleared", alloc_cnt, 0);
      for (int i = 0; i < BHT_INIT_CYCLES; i++) rnd(1);
      for (int i = 0; i < 40; i++) rnd(1'($urandom));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Sequences all writes into the 4-way, 16-set branch history table and the matching BTB allocation from the branch-resolve stage. Resolved branches are queued in a small FIFO and retired one per cycle as either a history update (BTB hit) or a new-entry allocation (BTB miss, LRU way cleared to TT). After reset it sweeps every set/way to the TT state before accepting resolutions. It sits between the resolve stage and the BHT/BTB write ports; the fetch-side read port is untouched.

## Interface
- `DEPTH`, 4: resolution FIFO entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `res_valid`  in  1  resolve stage presents a resolved branch.
- `res_ready`  out  1  controller accepts this cycle.
- `res_hit`  in  1  branch hit in the BTB at fetch.
- `res_way`  in  `lc3b_pc_ways`  way that hit (ignored on miss).
- `res_set`  in  `lc3b_set`  set index of the branch.
- `res_taken`  in  1  actual branch outcome.
- `lru_way`  in  `lc3b_pc_ways`  BTB LRU way for `bht_set`; combinational from the BTB.
- `bht_load`  out  1  BHT write enable.
- `bht_clear`  out  1  1 means allocate/clear the entry; 0 means update the history.
- `bht_br_result`  out  1  outcome to BHT.
- `bht_way`  out  `lc3b_pc_ways`  way for a history update.
- `bht_lru`  out  `lc3b_pc_ways`  way for an allocation or clear.
- `bht_set`  out  `lc3b_set`  set written.
- `btb_alloc`  out  1  BTB allocates `bht_lru` in `bht_set` and updates its LRU.
- `init_busy`  out  1  init sweep in progress.
- `alloc_cnt`  out  16  BTB/BHT allocations since reset; saturates at 0xFFFF.

## Operation
- **FSM states:** `INIT`, `RUN`.
- **Reset:**
  - State goes to `INIT`; the FIFO is emptied and the init counter and `alloc_cnt` are set to 0.
  - A reset mid-operation discards every queued entry.
- **INIT:**
  - A 6-bit counter `{set[3:0], way[1:0]}` counts 0..63.
  - Each cycle drives `bht_load`=1, `bht_clear`=1, `bht_set`=counter set field, `bht_lru`=counter way field.
  - `btb_alloc`=0, `res_ready`=0, `init_busy`=1.
  - At count 63 the FSM moves to `RUN` on the next edge.
- **RUN:**
  - `res_ready` = FIFO not full.
  - A push occurs when `res_valid && res_ready`; the entry is `{hit, way, set, taken}`.
  - When the FIFO is not empty, the head pops every cycle.
  - **Pop, hit:** `bht_load`=1, `bht_clear`=0, `bht_way`=head way, `bht_set`=head set, `bht_br_result`=head taken.
  - **Pop, miss:** `bht_load`=1, `bht_clear`=1, `btb_alloc`=1, `bht_lru`=`lru_way`, `bht_set`=head set; `alloc_cnt` increments with saturation.
  - **FIFO empty:** `bht_load`=0, `btb_alloc`=0.
- **Simultaneous push and pop:** legal whenever not full. Occupancy is unchanged; the pointers wrap modulo `DEPTH`.
- **Ordering:** entries retire strictly in FIFO order. Two entries to the same set/way are applied in consecutive cycles; no coalescing.
- **Unused outputs:** when not asserted, `bht_way`, `bht_lru` and `bht_set` are don't-care. `bht_br_result` is 0.
- **Output reset values:**
  - `bht_load`=1, `bht_clear`=1, set 0, lru 0 (init slot 0).
  - `res_ready`=0, `btb_alloc`=0, `init_busy`=1, `alloc_cnt`=0.

## Timing
- Write outputs are combinational from the FSM/counter or the FIFO head. The BHT commits them at the end of the same cycle.
- **Latency:** an entry accepted at edge t is written to the BHT at edge t+1 when the FIFO was empty. Otherwise it is written after all older entries, one per cycle.
- **Throughput:** one retirement per cycle, so the FIFO never fills unless `DEPTH` pushes arrive while older entries are still waiting.
- **INIT length:** exactly 64 cycles after `rst` deasserts. `res_ready` first rises in cycle 65.

## Configuration
- `BP_UPD_BYPASS_EN`
  - **Defined:** in `RUN` with the FIFO empty, an accepted resolution drives the BHT outputs combinationally in the same cycle and is not enqueued. Latency is 0 (written at edge t).
  - **Undefined:** every resolution passes through the FIFO, with latency 1.
  - Ordering and `alloc_cnt` behaviour are identical in both builds.

## Structure
- **Shared package `lc3b_types`:**
  - Uses existing `lc3b_set` and `lc3b_pc_ways`.
  - Adds `bp_res_t`, a packed struct `{hit, way, set, taken}`.
  - Adds constants `BHT_SETS`=16, `BHT_WAYS`=4 and `BHT_INIT_CYCLES`=64.
- **Sub-module `bp_res_fifo`:** synchronous FIFO with parameter `DEPTH`, flags `full`/`empty`, synchronous reset. It holds `bp_res_t`.
- The FSM, init counter and statistics counter stay in `bp_update_ctrl`.

## Test plan
- **Reset release:**
  - Stimulus: release reset and hold `res_valid`=1.
  - Response: 64 clear writes covering set 0..15 × way 0..3 in order; `res_ready`=0 throughout, then `res_ready`=1 and `init_busy`=0 in cycle 65.
- **Single hit:**
  - Stimulus: one hit `{way=2, set=5, taken=0}` pushed into an empty FIFO.
  - Response: the next cycle shows `bht_load`=1, `bht_clear`=0, `bht_way`=2, `bht_set`=5, `bht_br_result`=0. With the macro defined, this appears in the same cycle instead.
- **Single miss:**
  - Stimulus: one miss with `set=9`, `lru_way`=3.
  - Response: `bht_clear`=1, `btb_alloc`=1, `bht_lru`=3, `bht_set`=9; `alloc_cnt` goes 0 to 1.
- **Full FIFO:**
  - Stimulus: `DEPTH`=4 entries pushed in consecutive cycles while the test forces the head to be held, then 5 continuous pushes.
  - Response: `res_ready`=0 while full; the 5 entries retire in order with nothing lost; pointers wrap correctly.
- **Reset mid-run:**
  - Stimulus: assert `rst` with 3 entries queued.
  - Response: nothing retires, and the INIT sweep restarts at set 0, way 0.
- **Counter saturation:**
  - Stimulus: force `alloc_cnt` to 0xFFFE, then send 3 misses.
  - Response: the count reads 0xFFFF and holds there.
